// File: rtl/hero_pkg.sv
// Shared encodings for the hero movement controller: FSM states, facing codes
// and the per-level spawn table (indexed by level[1:0]).
package hero_pkg;

  localparam logic [1:0] ST_MOVE   = 2'd0;
  localparam logic [1:0] ST_EXIT   = 2'd1;
  localparam logic [1:0] ST_PARK   = 2'd2;
  localparam logic [1:0] ST_FREEZE = 2'd3;

  typedef logic [1:0] dir_t;
  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  // No entry may coincide with the exit tile, or a respawn would exit at once.
  function automatic logic [11:0] spawn_x(input logic [1:0] idx);
    case (idx)
      2'd0:    spawn_x = 12'd481;
      2'd1:    spawn_x = 12'd161;
      2'd2:    spawn_x = 12'd801;
      default: spawn_x = 12'd481;
    endcase
  endfunction

  function automatic logic [11:0] spawn_y(input logic [1:0] idx);
    case (idx)
      2'd3:    spawn_y = 12'd364;
      default: spawn_y = 12'd620;
    endcase
  endfunction

endpackage

// File: rtl/hero_step_clamp.sv
// One-axis next coordinate: pos +/- STEP, then saturate to [MIN, MAX] or wrap
// around the bounds when WRAP is set. Purely combinational.
module hero_step_clamp #(
  parameter int STEP = 2,
  parameter int MIN  = 128,
  parameter int MAX  = 896,
  parameter bit WRAP = 1'b0
) (
  input  logic [11:0] i_pos,
  input  logic        i_inc,
  output logic [11:0] o_pos
);

  localparam logic signed [13:0] L_STEP = 14'(STEP);
  localparam logic signed [13:0] L_MIN  = 14'(MIN);
  localparam logic signed [13:0] L_MAX  = 14'(MAX);
  localparam logic signed [13:0] L_ONE  = 14'sd1;

  // Signed intermediate keeps a sub-zero result visible instead of wrapping at 12 bits.
  logic signed [13:0] w_new;
  logic signed [13:0] w_wrap_lo;
  logic signed [13:0] w_wrap_hi;

  assign w_new     = i_inc ? ($signed({2'b00, i_pos}) + L_STEP)
                           : ($signed({2'b00, i_pos}) - L_STEP);
  assign w_wrap_lo = L_MAX - (L_MIN - w_new - L_ONE);
  assign w_wrap_hi = L_MIN + (w_new - L_MAX - L_ONE);

  always_comb begin
    o_pos = w_new[11:0];
    if (w_new < L_MIN) begin
      o_pos = WRAP ? w_wrap_lo[11:0] : L_MIN[11:0];
    end else if (w_new > L_MAX) begin
      o_pos = WRAP ? w_wrap_hi[11:0] : L_MAX[11:0];
    end
  end

endmodule

// File: rtl/hero_move_ctl.sv
// Hero position FSM (MOVE/EXIT/PARK/FREEZE) paced by frame_tick, with respawn
// and input lockout. Define HERO_MOVE_WRAP_EN to make horizontal moves wrap.
module hero_move_ctl
  import hero_pkg::*;
#(
  parameter int STEP          = 2,
  parameter int X_MIN         = 128,
  parameter int X_MAX         = 896,
  parameter int Y_MIN         = 108,
  parameter int Y_MAX         = 620,
  parameter int EXIT_X        = 481,
  parameter int EXIT_Y        = 108,
  parameter int FREEZE_FRAMES = 60,
  parameter int PARK_X        = 0,
  parameter int PARK_Y        = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frame_tick,
  input  logic        i_btn_up,
  input  logic        i_btn_down,
  input  logic        i_btn_left,
  input  logic        i_btn_right,
  input  logic        i_hero_rst,
  input  logic [3:0]  i_level,
  output logic [11:0] o_hero_x_pos,
  output logic [11:0] o_hero_y_pos,
  output logic [1:0]  o_hero_dir,
  output logic        o_hero_frozen
);

`ifdef HERO_MOVE_WRAP_EN
  localparam bit L_WRAP = 1'b1;
`else
  localparam bit L_WRAP = 1'b0;
`endif

  localparam int          L_FREEZE = (FREEZE_FRAMES < 1) ? 1 : FREEZE_FRAMES;
  localparam logic [15:0] L_CNT_LD = 16'(L_FREEZE);
  localparam logic [11:0] L_EXIT_X = 12'(EXIT_X);
  localparam logic [11:0] L_EXIT_Y = 12'(EXIT_Y);
  localparam logic [12:0] L_SNAP_Y = 13'(EXIT_Y + STEP);

  logic [1:0]  r_state;
  logic [11:0] r_x;
  logic [11:0] r_y;
  dir_t        r_dir;
  logic        r_frozen;
  logic [15:0] r_cnt;

  logic        w_up, w_dn, w_lf, w_rt, w_any;
  dir_t        w_dir;
  logic [11:0] w_x_step, w_y_step;
  logic [11:0] w_nx, w_ny;

  assign w_up  = i_btn_up;
  assign w_dn  = !i_btn_up && i_btn_down;
  assign w_lf  = !i_btn_up && !i_btn_down && i_btn_left;
  assign w_rt  = !i_btn_up && !i_btn_down && !i_btn_left && i_btn_right;
  assign w_any = w_up || w_dn || w_lf || w_rt;
  assign w_dir = w_up ? DIR_UP : (w_dn ? DIR_DOWN : (w_lf ? DIR_LEFT : DIR_RIGHT));

  hero_step_clamp #(.STEP(STEP), .MIN(X_MIN), .MAX(X_MAX), .WRAP(L_WRAP)) u_x_step (
    .i_pos (r_x),
    .i_inc (w_rt),
    .o_pos (w_x_step)
  );

  hero_step_clamp #(.STEP(STEP), .MIN(Y_MIN), .MAX(Y_MAX), .WRAP(1'b0)) u_y_step (
    .i_pos (r_y),
    .i_inc (w_dn),
    .o_pos (w_y_step)
  );

  // Exit snap compares old Y against EXIT_Y+STEP so no subtraction can underflow.
  always_comb begin
    w_nx = (w_lf || w_rt) ? w_x_step : r_x;
    w_ny = (w_up || w_dn) ? w_y_step : r_y;
    if (w_up && (r_x == L_EXIT_X) && ({1'b0, r_y} <= L_SNAP_Y)) begin
      w_ny = L_EXIT_Y;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_MOVE;
      r_x      <= spawn_x(2'd0);
      r_y      <= spawn_y(2'd0);
      r_dir    <= DIR_UP;
      r_frozen <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == ST_EXIT) begin
      r_state  <= ST_PARK;
      r_x      <= 12'(PARK_X);
      r_y      <= 12'(PARK_Y);
      r_frozen <= 1'b1;
    end else if (i_hero_rst) begin
      r_state  <= ST_FREEZE;
      r_x      <= spawn_x(i_level[1:0]);
      r_y      <= spawn_y(i_level[1:0]);
      r_frozen <= 1'b1;
      r_cnt    <= L_CNT_LD;
    end else begin
      case (r_state)
        ST_MOVE: begin
          if (i_frame_tick && w_any) begin
            r_x   <= w_nx;
            r_y   <= w_ny;
            r_dir <= w_dir;
            if ((w_nx == L_EXIT_X) && (w_ny == L_EXIT_Y)) begin
              r_state <= ST_EXIT;
            end
          end
        end
        ST_FREEZE: begin
          if (i_frame_tick) begin
            if (r_cnt <= 16'd1) begin
              r_state  <= ST_MOVE;
              r_frozen <= 1'b0;
              r_cnt    <= '0;
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_hero_x_pos  = r_x;
  assign o_hero_y_pos  = r_y;
  assign o_hero_dir    = r_dir;
  assign o_hero_frozen = r_frozen;

endmodule

// File: tb/tb_hero_move_ctl.sv
// Self-checking bench for hero_move_ctl: vector table, directed corner sequences,
// then random stimulus against a rule-level reference model.
module tb_hero_move_ctl;

`ifdef HERO_MOVE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        bu = 1'b0, bd = 1'b0, bl = 1'b0, br = 1'b0;
  logic        hrst = 1'b0;
  logic [3:0]  level = 4'd0;
  logic [11:0] x, y;
  logic [1:0]  dir;
  logic        frz;

  int total = 0;
  int bad   = 0;
  int exit_seen = 0;

  hero_move_ctl dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_frame_tick  (tick),
    .i_btn_up      (bu),
    .i_btn_down    (bd),
    .i_btn_left    (bl),
    .i_btn_right   (br),
    .i_hero_rst    (hrst),
    .i_level       (level),
    .o_hero_x_pos  (x),
    .o_hero_y_pos  (y),
    .o_hero_dir    (dir),
    .o_hero_frozen (frz)
  );

  always #5 clk = ~clk;

  // Level manager stand-in: counts clocks on which the hero sits on the exit tile.
  always @(negedge clk) begin
    if (!rst && x == 12'd481 && y == 12'd108) exit_seen <= exit_seen + 1;
  end

  int SPX[4] = '{481, 161, 801, 481};
  int SPY[4] = '{620, 620, 620, 364};

  // Reference model: mode 0 roaming, 1 on exit, 2 parked, 3 locked out.
  int m_mode, mx, my, mdir, mfrz, mcnt;

  task automatic model_reset();
    m_mode = 0; mx = 481; my = 620; mdir = 0; mfrz = 0; mcnt = 0;
  endtask

  task automatic model_update();
    int nx, ny;
    if (m_mode == 1) begin
      m_mode = 2; mx = 0; my = 0; mfrz = 1;
    end else if (hrst) begin
      mx = SPX[level % 4]; my = SPY[level % 4]; mcnt = 60; mfrz = 1; m_mode = 3;
    end else if (m_mode == 0 && tick && (bu || bd || bl || br)) begin
      nx = mx; ny = my;
      if (bu) begin
        mdir = 0; ny = my - 2;
        if (mx == 481 && ny <= 108) ny = 108;
        if (ny < 108) ny = 108;
      end else if (bd) begin
        mdir = 1; ny = (my + 2 > 620) ? 620 : my + 2;
      end else if (bl) begin
        mdir = 2; nx = mx - 2;
        if (nx < 128) nx = WRAP ? 896 - (128 - nx - 1) : 128;
      end else begin
        mdir = 3; nx = mx + 2;
        if (nx > 896) nx = WRAP ? 128 + (nx - 896 - 1) : 896;
      end
      mx = nx; my = ny;
      if (mx == 481 && my == 108) m_mode = 1;
    end else if (m_mode == 3 && tick) begin
      if (mcnt == 1) begin m_mode = 0; mfrz = 0; end
      else mcnt = mcnt - 1;
    end
  endtask

  task automatic chk(input string name, input int ex, input int ey, input int ed, input int ef);
    total++;
    if ({x, y, dir, frz} !== {12'(ex), 12'(ey), 2'(ed), 1'(ef)}) begin
      bad++;
      $display("FAIL %s: got x=%0d y=%0d dir=%0d frz=%0d, want x=%0d y=%0d dir=%0d frz=%0d",
               name, x, y, dir, frz, ex, ey, ed, ef);
    end
  endtask

  task automatic drive(input bit u, input bit d, input bit l, input bit r,
                       input bit t, input bit h, input int lv);
    bu = u; bd = d; bl = l; br = r; tick = t; hrst = h; level = 4'(lv);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // One frame: a tick cycle followed by an idle cycle with the same buttons held.
  task automatic frame(input bit u, input bit d, input bit l, input bit r);
    drive(u, d, l, r, 1, 0, 0); step();
    drive(u, d, l, r, 0, 0, 0); step();
  endtask

  task automatic async_reset();
    rst = 1'b1; #2; rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit u, d, l, r, t;
    int ex, ey, ed, ef;
  } vec_t;
  vec_t tbl[9];

  initial begin
    tbl[0] = '{0, 0, 0, 1, 1, 483, 620, 3, 0};
    tbl[1] = '{0, 0, 0, 1, 1, 485, 620, 3, 0};
    tbl[2] = '{0, 0, 0, 1, 1, 487, 620, 3, 0};
    tbl[3] = '{0, 0, 0, 1, 0, 487, 620, 3, 0};
    tbl[4] = '{1, 0, 0, 0, 0, 487, 620, 3, 0};
    tbl[5] = '{0, 0, 1, 0, 1, 485, 620, 2, 0};
    tbl[6] = '{0, 1, 0, 0, 1, 485, 620, 1, 0};
    tbl[7] = '{0, 0, 0, 0, 1, 485, 620, 1, 0};
    tbl[8] = '{1, 0, 1, 0, 1, 485, 618, 0, 0};

    #1 rst = 1'b1;
    #2 chk("reset", 481, 620, 0, 0);
    model_reset();
    @(negedge clk) rst = 1'b0;
    #1;

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].u, tbl[i].d, tbl[i].l, tbl[i].r, tbl[i].t, 0, 0);
      step();
      chk($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ed, tbl[i].ef);
    end

    // Left edge: saturate (or wrap) at X_MIN.
    async_reset();
    for (int i = 0; i < 176; i++) frame(0, 0, 1, 0);
    chk("left_129", 129, 620, 2, 0);
    frame(0, 0, 1, 0);
    chk("left_edge1", WRAP ? 896 : 128, 620, 2, 0);
    frame(0, 0, 1, 0);
    chk("left_edge2", WRAP ? 894 : 128, 620, 2, 0);

    // Walk up to the exit; hero_rst during EXIT must be ignored.
    async_reset();
    for (int i = 0; i < 255; i++) frame(1, 0, 0, 0);
    chk("near_exit", 481, 110, 0, 0);
    drive(1, 0, 0, 0, 1, 0, 0); step();
    chk("exit_pos", 481, 108, 0, 0);
    drive(1, 0, 0, 0, 1, 1, 0); step();
    chk("park", 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) frame(0, 1, 0, 0);
    chk("park_hold", 0, 0, 0, 1);
    total++;
    if (exit_seen != 1) begin
      bad++;
      $display("FAIL lm_once: exit cycles seen=%0d, want 1", exit_seen);
    end

    drive(0, 0, 0, 0, 0, 1, exit_seen); step();
    chk("respawn_l1", 161, 620, 0, 1);
    for (int i = 0; i < 59; i++) frame(0, 1, 0, 0);
    chk("freeze59", 161, 620, 0, 1);
    frame(0, 1, 0, 0);
    chk("freeze60", 161, 620, 0, 0);
    frame(0, 1, 0, 0);
    chk("down_clamp", 161, 620, 1, 0);

    // Respawn during FREEZE reloads the counter and beats a coincident tick.
    drive(0, 0, 0, 0, 0, 1, 1); step();
    for (int i = 0; i < 30; i++) frame(0, 0, 0, 0);
    chk("freeze30", 161, 620, 1, 1);
    drive(0, 0, 0, 0, 1, 1, 3); step();
    chk("respawn_l3", 481, 364, 1, 1);
    for (int i = 0; i < 59; i++) frame(1, 0, 0, 0);
    chk("reload59", 481, 364, 1, 1);
    frame(1, 0, 0, 0);
    chk("reload60", 481, 364, 1, 0);

    // Asynchronous reset mid-FREEZE, checked before the next clock edge.
    drive(0, 0, 0, 0, 0, 1, 2); step();
    for (int i = 0; i < 5; i++) frame(0, 0, 0, 0);
    chk("pre_rst", 801, 620, 1, 1);
    rst = 1'b1;
    #2 chk("async_rst", 481, 620, 0, 0);
    @(negedge clk) rst = 1'b0;
    model_reset();
    #1;

    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0,
            int'($urandom_range(0, 15)));
      step();
      chk("random", mx, my, mdir, mfrz);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
